// File: rtl/arm_pkg.sv
// Definitions shared by the MEM-stage SRAM controller and the EXE address logic.
package arm_pkg;

    localparam int SRAM_AW  = 18;
    localparam int SRAM_DW  = 16;
    localparam int MEM_BASE = 1024;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } sram_state_t;

endpackage

// File: rtl/sram_controller.sv
// Performs a 32-bit MEM-stage load/store as two half-word accesses on a 16-bit
// asynchronous SRAM, holding ready low while the access is in flight.
module sram_controller
    import arm_pkg::*;
#(
    parameter int BASE_ADDR   = MEM_BASE,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               memReadEn,
    input  logic               memWriteEn,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [SRAM_DW-1:0] SRAM_DQ_out,
    output logic               SRAM_DQ_oe,
    input  logic [SRAM_DW-1:0] SRAM_DQ_in,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N
);

    localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    sram_state_t         r_state;
    logic [CW-1:0]       r_cnt;
    logic [16:0]         r_wa;
    logic [SRAM_DW-1:0]  r_wdata_hi;
    logic [SRAM_DW-1:0]  r_shadow_lo;

    logic [16:0]         w_wa;
    logic                w_last;

    // Word index wraps modulo 2^17 for addresses below the base or past the top.
    assign w_wa   = 17'((address - 32'(BASE_ADDR)) >> 2);
    assign w_last = (r_cnt == '0);
    assign ready  = !(memReadEn || memWriteEn) || (r_state == DONE);

    // Pad outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_wa        <= '0;
            r_wdata_hi  <= '0;
            r_shadow_lo <= '0;
            readData    <= '0;
            SRAM_ADDR   <= '0;
            SRAM_DQ_out <= '0;
            SRAM_DQ_oe  <= 1'b0;
            SRAM_WE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wa       <= w_wa;
                    r_wdata_hi <= writeData[31:16];
                    if (memWriteEn) begin
                        r_state     <= WR_LO;
                        r_cnt       <= CNT_LOAD;
                        SRAM_ADDR   <= {w_wa, 1'b0};
                        SRAM_DQ_out <= writeData[15:0];
                        SRAM_DQ_oe  <= 1'b1;
                        SRAM_WE_N   <= 1'b0;
                        SRAM_OE_N   <= 1'b1;
                    end else if (memReadEn) begin
                        r_state    <= RD_LO;
                        r_cnt      <= CNT_LOAD;
                        SRAM_ADDR  <= {w_wa, 1'b0};
                        SRAM_DQ_oe <= 1'b0;
                        SRAM_WE_N  <= 1'b1;
                        SRAM_OE_N  <= 1'b0;
                    end
                end
                RD_LO: begin
                    if (w_last) begin
                        r_shadow_lo <= SRAM_DQ_in;
                        r_state     <= RD_HI;
                        r_cnt       <= CNT_LOAD;
                        SRAM_ADDR   <= {r_wa, 1'b1};
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                RD_HI: begin
                    if (w_last) begin
                        readData  <= {SRAM_DQ_in, r_shadow_lo};
                        r_state   <= DONE;
                        SRAM_OE_N <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                WR_LO: begin
                    if (w_last) begin
                        r_state     <= WR_HI;
                        r_cnt       <= CNT_LOAD;
                        SRAM_ADDR   <= {r_wa, 1'b1};
                        SRAM_DQ_out <= r_wdata_hi;
                        SRAM_WE_N   <= 1'b0;
                    end else begin
                        // WE rises for the final cycle so address/data hold across the edge.
                        r_cnt     <= r_cnt - CNT_ONE;
                        SRAM_WE_N <= (r_cnt == CNT_ONE);
                    end
                end
                WR_HI: begin
                    if (w_last) begin
                        r_state    <= DONE;
                        SRAM_DQ_oe <= 1'b0;
                    end else begin
                        r_cnt     <= r_cnt - CNT_ONE;
                        SRAM_WE_N <= (r_cnt == CNT_ONE);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state    <= IDLE;
                    SRAM_DQ_oe <= 1'b0;
                    SRAM_WE_N  <= 1'b1;
                    SRAM_OE_N  <= 1'b1;
                end
            endcase
        end
    end

endmodule
